mrv1_th_sched: RTL and testbench
================================

# mrv1_th_sched

Per-thread lifecycle tracker and round-robin issue scheduler for the multithreaded core. It holds a three-state machine per hardware thread (IDLE, READY, WAIT) and arbitrates fairly among READY threads. It presents one thread ID per cycle to the issue stage over a valid/ready handshake. It sits between the thread-control and long-latency-completion logic on one side and the issue stage on the other.

## Interface
Parameters:
- NUM_THREADS_P, 8, number of hardware threads (≥2).
- QUANTUM_P, 4, consecutive accepted issues per grant; used only with MRV1_TH_SCHED_QUANTUM_EN (≥1).
- TID_WIDTH_LP, $clog2(NUM_THREADS_P), thread ID width (local).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous active-high reset.
- th_start_i  in  1  activate thread th_start_tid_i.
- th_start_tid_i  in  TID_WIDTH_LP  thread to activate.
- th_kill_i  in  1  deactivate thread th_kill_tid_i.
- th_kill_tid_i  in  TID_WIDTH_LP  thread to deactivate.
- blk_i  in  1  block thread blk_tid_i (long-latency op issued).
- blk_tid_i  in  TID_WIDTH_LP  thread to block.
- wake_i  in  NUM_THREADS_P  per-thread wake mask (long-latency op done).
- issue_vld_o  out  1  a READY thread is offered.
- issue_tid_o  out  TID_WIDTH_LP  offered thread.
- issue_rdy_i  in  1  issue stage accepts the offered thread.
- th_active_o  out  NUM_THREADS_P  thread not IDLE.
- th_ready_o  out  NUM_THREADS_P  thread in READY.

## Operation
Per-thread state machine; reset state IDLE:
- IDLE→READY on th_start_i for that tid.
- READY or WAIT→IDLE on th_kill_i for that tid.
- READY→WAIT on blk_i for that tid.
- WAIT→READY on wake_i[tid].
- Events that do not match the current state are ignored (start on non-IDLE, kill on IDLE, blk on non-READY, wake on non-WAIT).

Same-tid priority, same cycle: kill > start > blk > wake.
- Kill plus start → IDLE.
- Blk plus wake on a READY thread → WAIT; the wake is lost, and the producer must not wake in the block cycle.

Arbitration:
- Register rr_q holds the last granted tid.
- Search order is rr_q+1, rr_q+2, … wrapping modulo NUM_THREADS_P, ending at rr_q itself.
- The first READY thread found is offered.

Lock:
- lock_q is set while issue_vld_o=1 and issue_rdy_i=0.
- While lock_q is set, issue_tid_o must hold its value.
- The lock releases when:
  - the handshake completes, or
  - the locked thread leaves READY (blk or kill). In that case arbitration re-runs the next cycle, and vld may drop or the tid may change.

Accept (issue_vld_o & issue_rdy_i):
- Without the macro, rr_q ← issue_tid_o.
- An accept in the same cycle as blk or kill of that tid still counts as issued. The state transition is applied as well.

Idle and reset outputs:
- issue_tid_o = 0 whenever issue_vld_o = 0.
- Reset: all threads IDLE; rr_q = NUM_THREADS_P-1, so the first search starts at tid 0; lock_q = 0; quantum counter = 0.
- Every output is 0 during reset.

## Timing
- issue_vld_o, issue_tid_o, th_active_o and th_ready_o are functions of registers only.
- There is no combinational path from any input to any output, in particular none from issue_rdy_i.
- State changes take effect at the next posedge and are visible the following cycle:
  - a thread started in cycle t can be offered in cycle t+1;
  - a thread woken in cycle t can be offered in cycle t+1.
- With rdy held at 1, one accept per cycle is sustained; there are no bubbles when switching threads.
- rst_i asserts asynchronously: outputs go to reset values without waiting for a clock edge. Deassertion is synchronous to the system.

## Configuration
Macro: MRV1_TH_SCHED_QUANTUM_EN.

- Defined:
  - A counter of $clog2(QUANTUM_P+1) bits counts accepts for the currently granted thread.
  - The grant stays on that thread while it remains READY and the count is below QUANTUM_P.
  - rr_q advances to the granted tid, and the counter clears, when the count reaches QUANTUM_P or the thread leaves READY.
  - The counter also clears whenever the granted tid changes.
- Undefined: pure per-issue round-robin (rr_q updates on every accept). No counter logic is present and QUANTUM_P is unused.

## Test plan
1. Reset, start tids 0, 3, 5 in one cycle each, rdy=1 → accepted sequence 0, 3, 5, 0, 3, 5; th_active_o=0x29.
2. Tid 3 offered, rdy=0 for 3 cycles → issue_tid_o stays 3 for all 3 cycles. Then rdy=1 → accept 3, next offer 5.
3. Tid 3 offered with rdy=0, blk_i on tid 3 → next cycle tid 5 offered and th_ready_o[3]=0. wake_i[3] later → 3 rejoins in round-robin order after the current grant.
4. Same cycle kill+start on tid 2 → tid 2 stays IDLE. Same cycle blk+wake on READY tid 0 → tid 0 in WAIT. start on active tid 3 → no change.
5. MRV1_TH_SCHED_QUANTUM_EN defined, QUANTUM_P=2, tids 0 and 1 READY, rdy=1 → accepted sequence 0, 0, 1, 1, 0, 0.
6. Async reset pulse mid-stream, between clock edges → issue_vld_o=0 and th_active_o=0 immediately. After release and start of tid 4 → first offer is tid 4.

Source files
------------

// File: rtl/mrv1_th_sched.sv
// Per-thread IDLE/READY/WAIT tracker with a round-robin issue arbiter and a sticky offer lock.
// Optional per-grant issue quantum is enabled with the MRV1_TH_SCHED_QUANTUM_EN macro.
module mrv1_th_sched #(
  parameter  int NUM_THREADS_P = 8,
  parameter  int QUANTUM_P     = 4,
  localparam int TID_WIDTH_LP  = $clog2(NUM_THREADS_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     th_start_i,
  input  logic [TID_WIDTH_LP-1:0]  th_start_tid_i,
  input  logic                     th_kill_i,
  input  logic [TID_WIDTH_LP-1:0]  th_kill_tid_i,
  input  logic                     blk_i,
  input  logic [TID_WIDTH_LP-1:0]  blk_tid_i,
  input  logic [NUM_THREADS_P-1:0] wake_i,
  output logic                     issue_vld_o,
  output logic [TID_WIDTH_LP-1:0]  issue_tid_o,
  input  logic                     issue_rdy_i,
  output logic [NUM_THREADS_P-1:0] th_active_o,
  output logic [NUM_THREADS_P-1:0] th_ready_o
);

  typedef enum logic [1:0] {TH_IDLE, TH_READY, TH_WAIT} th_state_e;

  th_state_e                state_q [NUM_THREADS_P];
  logic [NUM_THREADS_P-1:0] ready;
  logic [NUM_THREADS_P-1:0] start_hit, kill_hit, blk_hit, leave;
  logic [TID_WIDTH_LP-1:0]  rr_q, lock_tid_q, rr_tid, offer_tid;
  logic                     lock_q, rr_found, offer_vld, accept;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    ready       = '0;
    th_active_o = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      ready[t]       = (state_q[t] == TH_READY);
      th_active_o[t] = (state_q[t] != TH_IDLE);
    end
  end

  assign th_ready_o = ready;
  assign start_hit  = NUM_THREADS_P'(th_start_i) << th_start_tid_i;
  assign kill_hit   = NUM_THREADS_P'(th_kill_i) << th_kill_tid_i;
  assign blk_hit    = NUM_THREADS_P'(blk_i) << blk_tid_i;
  assign leave      = ready & (blk_hit | kill_hit);

  // Search rr_q+1 .. rr_q (wrapping) for the first READY thread.
  always_comb begin : arb_search
    logic [TID_WIDTH_LP:0]   idx;
    logic [TID_WIDTH_LP-1:0] cand;
    rr_found = 1'b0;
    rr_tid   = '0;
    idx      = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_THREADS_P; i++) begin
      idx = {1'b0, rr_q} + (TID_WIDTH_LP+1)'(i);
      if (idx >= (TID_WIDTH_LP+1)'(NUM_THREADS_P))
        idx = idx - (TID_WIDTH_LP+1)'(NUM_THREADS_P);
      cand = idx[TID_WIDTH_LP-1:0];
      if (!rr_found && ready[cand]) begin
        rr_found = 1'b1;
        rr_tid   = cand;
      end
    end
  end

`ifdef MRV1_TH_SCHED_QUANTUM_EN
  localparam int CNT_W = $clog2(QUANTUM_P + 1);

  logic [CNT_W-1:0]        cnt_q, cnt_inc;
  logic [TID_WIDTH_LP-1:0] cur_q;
  logic                    hold;

  assign hold    = (cnt_q != '0) && ready[cur_q];
  assign cnt_inc = ((cnt_q != '0) && (offer_tid == cur_q)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
`endif

  always_comb begin
    offer_vld = rr_found;
    offer_tid = rr_tid;
`ifdef MRV1_TH_SCHED_QUANTUM_EN
    if (hold) begin
      offer_vld = 1'b1;
      offer_tid = cur_q;
    end
`endif
    // A locked thread is always still READY: leaving READY releases the lock at the same edge.
    if (lock_q) begin
      offer_vld = 1'b1;
      offer_tid = lock_tid_q;
    end
  end

  assign issue_vld_o = offer_vld;
  assign issue_tid_o = offer_vld ? offer_tid : '0;
  assign accept      = offer_vld & issue_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the state array is reset explicitly; IDLE on reset is part of the thread contract.
      for (int t = 0; t < NUM_THREADS_P; t++) state_q[t] <= TH_IDLE;
      rr_q       <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
      lock_q     <= 1'b0;
      lock_tid_q <= '0;
`ifdef MRV1_TH_SCHED_QUANTUM_EN
      cnt_q      <= '0;
      cur_q      <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all updates see pre-edge values.
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        if (kill_hit[t]) begin
          state_q[t] <= TH_IDLE;
        end else begin
          unique case (state_q[t])
            TH_IDLE:  if (start_hit[t]) state_q[t] <= TH_READY;
            TH_READY: if (blk_hit[t])   state_q[t] <= TH_WAIT;
            TH_WAIT:  if (wake_i[t])    state_q[t] <= TH_READY;
            default:                    state_q[t] <= TH_IDLE;
          endcase
        end
      end

      lock_q     <= offer_vld & ~issue_rdy_i & ~leave[offer_tid];
      lock_tid_q <= offer_tid;

`ifdef MRV1_TH_SCHED_QUANTUM_EN
      if (accept) begin
        if ((cnt_inc == CNT_W'(QUANTUM_P)) || leave[offer_tid]) begin
          rr_q  <= offer_tid;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_inc;
          cur_q <= offer_tid;
        end
      end else if ((cnt_q != '0) && leave[cur_q]) begin
        rr_q  <= cur_q;
        cnt_q <= '0;
      end
`else
      if (accept) rr_q <= offer_tid;
`endif
    end
  end

endmodule

// File: tb/tb_mrv1_th_sched.sv
// Self-checking bench for mrv1_th_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a thread-level reference model.
module tb_mrv1_th_sched;

  localparam int N  = 8;
  localparam int TW = 3;
  localparam int Q  = 2;
`ifdef MRV1_TH_SCHED_QUANTUM_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_READY = 1, S_WAIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          th_start, th_kill, blk, issue_rdy;
  logic [TW-1:0] th_start_tid, th_kill_tid, blk_tid;
  logic [N-1:0]  wake;
  logic          issue_vld;
  logic [TW-1:0] issue_tid;
  logic [N-1:0]  th_active, th_ready;

  int n_cmp = 0;
  int n_err = 0;
  int acc_q[$];

  // Reference model state
  int m_st[N];
  int m_rr, m_lock, m_lock_tid, m_cnt, m_cur;

  mrv1_th_sched #(.NUM_THREADS_P(N), .QUANTUM_P(Q)) dut (
    .clk_i(clk), .rst_i(rst),
    .th_start_i(th_start), .th_start_tid_i(th_start_tid),
    .th_kill_i(th_kill), .th_kill_tid_i(th_kill_tid),
    .blk_i(blk), .blk_tid_i(blk_tid), .wake_i(wake),
    .issue_vld_o(issue_vld), .issue_tid_o(issue_tid), .issue_rdy_i(issue_rdy),
    .th_active_o(th_active), .th_ready_o(th_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int t = 0; t < N; t++) m_st[t] = S_IDLE;
    m_rr = N - 1; m_lock = 0; m_lock_tid = 0; m_cnt = 0; m_cur = 0;
  endfunction

  function automatic void m_offer(output bit v, output int tid);
    v = 1'b0; tid = 0;
    if (m_lock != 0) begin
      v = 1'b1; tid = m_lock_tid;
    end else if (QEN && m_cnt > 0 && m_st[m_cur] == S_READY) begin
      v = 1'b1; tid = m_cur;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int t;
        t = (m_rr + k) % N;
        if (!v && m_st[t] == S_READY) begin v = 1'b1; tid = t; end
      end
    end
  endfunction

  function automatic logic [31:0] m_mask(input int which);
    logic [31:0] m;
    m = '0;
    for (int t = 0; t < N; t++)
      if ((which == 0) ? (m_st[t] != S_IDLE) : (m_st[t] == S_READY)) m[t] = 1'b1;
    return m;
  endfunction

  function automatic bit m_leave(input int t);
    return (m_st[t] == S_READY) &&
           ((blk && int'(blk_tid) == t) || (th_kill && int'(th_kill_tid) == t));
  endfunction

  // Compare all outputs with the model, advance the model, clock once, clear pulse inputs.
  task automatic step();
    bit ev;
    int et, n;
    int nst[N];
    m_offer(ev, et);
    check("vld", issue_vld, 32'(ev));
    check("tid", issue_tid, ev ? et : 0);
    check("active", th_active, m_mask(0));
    check("ready", th_ready, m_mask(1));
    if (issue_vld && issue_rdy) acc_q.push_back(int'(issue_tid));

    if (QEN) begin
      if (ev && issue_rdy) begin
        n = (m_cnt > 0 && et == m_cur) ? m_cnt + 1 : 1;
        if (n == Q || m_leave(et)) begin m_rr = et; m_cnt = 0; end
        else begin m_cnt = n; m_cur = et; end
      end else if (m_cnt > 0 && m_leave(m_cur)) begin
        m_rr = m_cur; m_cnt = 0;
      end
    end else if (ev && issue_rdy) begin
      m_rr = et;
    end
    m_lock     = (ev && !issue_rdy && !m_leave(et)) ? 1 : 0;
    m_lock_tid = et;

    for (int t = 0; t < N; t++) begin
      nst[t] = m_st[t];
      if (th_kill && int'(th_kill_tid) == t)                         nst[t] = S_IDLE;
      else if (m_st[t] == S_IDLE && th_start && int'(th_start_tid) == t) nst[t] = S_READY;
      else if (m_st[t] == S_READY && blk && int'(blk_tid) == t)      nst[t] = S_WAIT;
      else if (m_st[t] == S_WAIT && wake[t])                         nst[t] = S_READY;
    end
    for (int t = 0; t < N; t++) m_st[t] = nst[t];

    @(posedge clk);
    #1;
    th_start = 1'b0; th_kill = 1'b0; blk = 1'b0; wake = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check("rst_vld", issue_vld, 0);
    check("rst_tid", issue_tid, 0);
    check("rst_active", th_active, 0);
    check("rst_ready", th_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start(input int t);
    th_start = 1'b1; th_start_tid = TW'(t);
  endtask

  initial begin
    rst = 1'b0; th_start = 1'b0; th_kill = 1'b0; blk = 1'b0; wake = '0; issue_rdy = 1'b0;
    th_start_tid = '0; th_kill_tid = '0; blk_tid = '0;
    m_reset();
    @(posedge clk); #1;
    do_reset();

    // Start 0, 3, 5 back to back with the issue stage always ready
    start(0); step();
    issue_rdy = 1'b1;
    start(3); step();
    start(5); step();
    check("active_after_start", th_active, 32'h29);
    repeat (4) step();
`ifndef MRV1_TH_SCHED_QUANTUM_EN
    begin
      int exp_seq[6] = '{0, 3, 5, 0, 3, 5};
      check("rr_seq_len", acc_q.size(), 6);
      for (int i = 0; i < 6 && i < acc_q.size(); i++) check("rr_seq", acc_q[i], exp_seq[i]);
    end
`endif

    // Offer held while the issue stage stalls
    step();
    issue_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
`ifndef MRV1_TH_SCHED_QUANTUM_EN
      check("stall_hold_tid", issue_tid, 3);
`endif
      step();
    end
    issue_rdy = 1'b1;
    step();
`ifndef MRV1_TH_SCHED_QUANTUM_EN
    check("after_stall_tid", issue_tid, 5);
`endif
    step();
    step();

    // Block the locked thread, then wake it
    issue_rdy = 1'b0;
    blk = 1'b1; blk_tid = 3'd3;
    step();
    check("blk_ready3", th_ready[3], 0);
`ifndef MRV1_TH_SCHED_QUANTUM_EN
    check("blk_next_tid", issue_tid, 5);
`endif
    step();
    wake[3] = 1'b1;
    step();
    issue_rdy = 1'b1;
    step();
`ifndef MRV1_TH_SCHED_QUANTUM_EN
    check("rejoin_tid0", issue_tid, 0);
`endif
    step();
`ifndef MRV1_TH_SCHED_QUANTUM_EN
    check("rejoin_tid3", issue_tid, 3);
`endif
    step();

    // Same-cycle priority cases
    issue_rdy = 1'b0;
    th_kill = 1'b1; th_kill_tid = 3'd2; start(2);
    step();
    check("kill_start_idle", th_active[2], 0);
    blk = 1'b1; blk_tid = 3'd0; wake[0] = 1'b1; start(3);
    step();
    check("blk_wake_ready", th_ready, 32'h28);
    check("blk_wake_active", th_active, 32'h29);
    wake[0] = 1'b1;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      th_start = ($urandom_range(2) == 0); th_start_tid = TW'($urandom_range(N - 1));
      th_kill  = ($urandom_range(9) == 0); th_kill_tid  = TW'($urandom_range(N - 1));
      blk      = ($urandom_range(3) == 0); blk_tid      = TW'($urandom_range(N - 1));
      wake     = N'($urandom) & N'($urandom);
      issue_rdy = ($urandom_range(3) != 0);
      step();
    end

    // Asynchronous reset pulse between edges
    issue_rdy = 1'b1;
    start(1); step();
    start(2); step();
    #2;
    do_reset();
    start(4); step();
    check("post_rst_vld", issue_vld, 1);
    check("post_rst_tid", issue_tid, 4);
    step();

`ifdef MRV1_TH_SCHED_QUANTUM_EN
    // Quantum of two issues per grant
    @(posedge clk); #1;
    do_reset();
    issue_rdy = 1'b0;
    start(0); step();
    start(1); step();
    issue_rdy = 1'b1;
    acc_q.delete();
    repeat (6) step();
    begin
      int exp_q[6] = '{0, 0, 1, 1, 0, 0};
      check("quantum_len", acc_q.size(), 6);
      for (int i = 0; i < 6 && i < acc_q.size(); i++) check("quantum_seq", acc_q[i], exp_q[i]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
